y_event_counter: RTL and testbench
==================================

# y_event_counter

Downstream consumer of the combinational AND-OR output Y. It synchronizes Y into the system clock domain, debounces it with a four-state FSM, and emits a one-cycle pulse per qualified rising edge. It also keeps a wrapping event count with a sticky overflow flag. It sits between the gate-level logic stage and the display/LED readout logic.

## Interface
Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on y_in (minimum 2)
- DEBOUNCE, 4, consecutive synchronized samples required to accept a level change (minimum 2)
- CNT_W, 8, event counter width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset: synchronous and active-high
- y_in  input  1  Y from the logic stage, asynchronous to clk
- enable  input  1  1 = qualified rising edges increment count
- clear  input  1  synchronous clear of count and overflow
- edge_pulse  output  1  one-cycle pulse per qualified rising edge
- count  output  CNT_W  number of qualified rising edges since reset/clear, modulo 2^CNT_W
- overflow  output  1  sticky, set when count wraps from all-ones to 0
- busy  output  1  1 when FSM is in RISE_CHK or FALL_CHK

## Operation
- The signal s is y_in after SYNC_STAGES flops. The flops reset to 0.
- The FSM uses a debounce counter dcnt of width $clog2(DEBOUNCE).
- FSM states and transitions:
  - LOW: s=1 → RISE_CHK with dcnt=1.
  - RISE_CHK:
    - s=0 → LOW with dcnt=0.
    - s=1 and dcnt==DEBOUNCE-1 → HIGH, and the edge is qualified.
    - Otherwise dcnt increments.
  - HIGH: s=0 → FALL_CHK with dcnt=1.
  - FALL_CHK:
    - s=1 → HIGH with dcnt=0.
    - s=0 and dcnt==DEBOUNCE-1 → LOW.
    - Otherwise dcnt increments.
  - Falling edges are never counted and produce no pulse.
- On a qualified edge, all three of these happen at the same clock edge as the transition:
  - edge_pulse is registered to 1 for exactly one cycle.
  - If enable=1 and clear=0, count increments.
  - If count was all-ones, count wraps to 0 and overflow is set to 1.
- enable=0 has no effect on the FSM or on edge_pulse; it only blocks the count increment.
- clear=1 forces count=0 and overflow=0 at the next edge.
  - clear overrides a simultaneous increment.
  - clear does not affect the FSM or edge_pulse.
- rst has priority over everything.
  - A partial debounce in progress is discarded.
  - If y_in is held high through reset release, it is counted once, after the full latency below.

## Timing
- Reset values: edge_pulse=0, count=0, overflow=0, busy=0, state=LOW, dcnt=0, sync flops=0.
- Rise latency: suppose y_in is high and stable from rising edge 0, where edge 0 is the first edge sampling it high.
  - edge_pulse and the updated count are visible after edge SYNC_STAGES+DEBOUNCE-1.
  - With defaults, that is after edge 5, i.e. on the 6th edge counting edge 0.
- Glitch rejection: a high pulse on s shorter than DEBOUNCE samples returns the FSM to LOW without a pulse.
  - Likewise, a low dip shorter than DEBOUNCE samples in HIGH returns the FSM to HIGH without a new pulse.
- Minimum spacing between two edge_pulses is 2·DEBOUNCE cycles.
- busy is registered from state. It is high in the cycles after entering RISE_CHK/FALL_CHK, and low again the cycle after leaving.
- count and overflow are registered outputs. No combinational path exists from any input to any output.

## Structure
- Shared package de_pkg holds:
  - the state encoding: ST_LOW=2'd0, ST_RISE_CHK=2'd1, ST_HIGH=2'd2, ST_FALL_CHK=2'd3;
  - the default parameter constants, for reuse by the display stage.
- Sub-module sync_chain (parameter STAGES) implements the reset-to-0 synchronizer flop chain. It is instantiated once for y_in.
- The FSM, debounce counter and event counter live in y_event_counter itself.

## Test plan
- Reset, then hold y_in high from edge 0 with defaults → edge_pulse high only in the cycle after edge 5. count=1 afterward, overflow=0.
- Apply y_in high pulses of 3 cycles (s high for 3 samples), then 4 cycles → no pulse for the 3-cycle pulse. One pulse for the 4-cycle pulse, count=1.
- Apply 256 clean rising edges with CNT_W=8 → count goes 255 then 0. overflow=1 from the 256th edge and stays 1 until clear.
- Hold enable=0 during 3 clean edges, then enable=1 for 2 edges → 5 edge_pulses, count=2.
- Assert clear in the same cycle a qualified edge occurs → count=0, overflow=0, edge_pulse still 1 for that cycle.
- Assert rst while in RISE_CHK with dcnt=2, keeping y_in high, then release → all outputs 0 during reset. One pulse after SYNC_STAGES+DEBOUNCE-1 edges from release, count=1.

Source files
------------

// File: rtl/de_pkg.sv
// de_pkg: definitions shared by y_event_counter and the display stage.
//   state_t         - debounce FSM state encoding
//   DEF_SYNC_STAGES - default synchronizer depth on y_in
//   DEF_DEBOUNCE    - default number of stable samples needed to accept a level
//   DEF_CNT_W       - default event counter width
package de_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE    = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: flop chain that brings an asynchronous level into the clk domain.
//   clk - system clock
//   rst - synchronous active-high reset, clears every stage to 0
//   d   - asynchronous input level
//   q   - synchronized level, STAGES clock edges behind d
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_reg[gi] <= 1'b0;
      end else if (gi == 0) begin
        sync_reg[gi] <= d;
      end else begin
        sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/y_event_counter.sv
// y_event_counter: synchronizes the logic-stage output Y, debounces it and
// counts its qualified rising edges.
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous active-high reset, highest priority
//   y_in       - Y from the logic stage, asynchronous to clk
//   enable     - 1 lets qualified rising edges increment count
//   clear      - synchronous clear of count and overflow
//   edge_pulse - one-cycle pulse per qualified rising edge
//   count      - qualified rising edges since reset/clear, modulo 2^CNT_W
//   overflow   - sticky, set when count wraps from all-ones to 0
//   busy       - 1 while the FSM is checking a level change
module y_event_counter
  import de_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             enable,
  input  logic             clear,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             busy
);

  localparam int             DW        = $clog2(DEBOUNCE);
  localparam logic [DW-1:0]  DCNT_ONE  = DW'(1);
  localparam logic [DW-1:0]  DCNT_LAST = DW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  state_t           state_reg, state_next;
  logic [DW-1:0]    dcnt_reg, dcnt_next;
  logic             qualified;
  logic             edge_pulse_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (y_in),
    .q  (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_LOW;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  // The first differing sample already counts as one, so the level is
  // accepted on the DEBOUNCE-th consecutive differing sample.
  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    qualified  = 1'b0;
    unique case (state_reg)
      ST_LOW: begin
        if (s) begin
          state_next = ST_RISE_CHK;
          dcnt_next  = DCNT_ONE;
        end
      end
      ST_RISE_CHK: begin
        if (!s) begin
          state_next = ST_LOW;
          dcnt_next  = '0;
        end else if (dcnt_reg == DCNT_LAST) begin
          state_next = ST_HIGH;
          dcnt_next  = '0;
          qualified  = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + DCNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_next = ST_FALL_CHK;
          dcnt_next  = DCNT_ONE;
        end
      end
      ST_FALL_CHK: begin
        if (s) begin
          state_next = ST_HIGH;
          dcnt_next  = '0;
        end else if (dcnt_reg == DCNT_LAST) begin
          state_next = ST_LOW;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_reg + DCNT_ONE;
        end
      end
      default: begin
        state_next = ST_LOW;
        dcnt_next  = '0;
      end
    endcase
  end

  // Pulse, busy and the counter all update on the same edge as the FSM
  // transition; clear wins over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_pulse_reg <= 1'b0;
      busy_reg       <= 1'b0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      edge_pulse_reg <= qualified;
      busy_reg       <= (state_next == ST_RISE_CHK) || (state_next == ST_FALL_CHK);
      if (clear) begin
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else if (qualified && enable) begin
        count_reg <= count_reg + CNT_ONE;
        if (&count_reg) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  assign edge_pulse = edge_pulse_reg;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_y_event_counter.sv
// tb_y_event_counter: directed and randomized checks of y_event_counter
// against a behavioural model (delay line + run-length debounce + counter).
module tb_y_event_counter;
  import de_pkg::*;

  localparam int SYNC_STAGES = DEF_SYNC_STAGES;
  localparam int DEBOUNCE    = DEF_DEBOUNCE;
  localparam int CNT_W       = DEF_CNT_W;
  localparam int CNT_MOD     = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             y_in = 1'b0;
  logic             enable = 1'b1;
  logic             clear = 1'b0;
  logic             edge_pulse;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             busy;

  y_event_counter #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .y_in      (y_in),
    .enable    (enable),
    .clear     (clear),
    .edge_pulse(edge_pulse),
    .count     (count),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: y_in samples delayed by SYNC_STAGES, an accepted level
  // that flips after DEBOUNCE consecutive differing samples, and a counter.
  bit q_m[$];
  bit level_m;
  int run_m;
  int cnt_m;
  bit ovf_m;
  bit pulse_m;
  bit busy_m;

  int pulses_seen;
  int first_idx;

  task automatic model_reset();
    q_m.delete();
    for (int i = 0; i < SYNC_STAGES; i++) q_m.push_back(1'b0);
    level_m = 1'b0;
    run_m   = 0;
    cnt_m   = 0;
    ovf_m   = 1'b0;
    pulse_m = 1'b0;
    busy_m  = 1'b0;
  endtask

  task automatic model_update();
    bit s_m;
    bit qual;
    if (rst) begin
      model_reset();
    end else begin
      s_m = q_m.pop_front();
      q_m.push_back(y_in);
      qual = 1'b0;
      if (s_m != level_m) begin
        run_m++;
        if (run_m == DEBOUNCE) begin
          level_m = s_m;
          run_m   = 0;
          qual    = s_m;
        end
      end else begin
        run_m = 0;
      end
      pulse_m = qual;
      busy_m  = (run_m != 0);
      if (clear) begin
        cnt_m = 0;
        ovf_m = 1'b0;
      end else if (qual && enable) begin
        if (cnt_m == CNT_MOD - 1) ovf_m = 1'b1;
        cnt_m = (cnt_m + 1) % CNT_MOD;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    vectors++;
    assert (edge_pulse === pulse_m) else begin
      miscompares++;
      $error("FAIL edge_pulse got %0b exp %0b at %0t", edge_pulse, pulse_m, $time);
    end
    assert (count === CNT_W'(cnt_m)) else begin
      miscompares++;
      $error("FAIL count got %0d exp %0d at %0t", count, cnt_m, $time);
    end
    assert (overflow === ovf_m) else begin
      miscompares++;
      $error("FAIL overflow got %0b exp %0b at %0t", overflow, ovf_m, $time);
    end
    assert (busy === busy_m) else begin
      miscompares++;
      $error("FAIL busy got %0b exp %0b at %0t", busy, busy_m, $time);
    end
  endtask

  task automatic check_eq(string tag, int got, int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
    $display("check %s: got %0d exp %0d", tag, got, exp);
  endtask

  // Holds y_in at v for n cycles, recording pulses seen and the first one's index.
  task automatic run_level(bit v, int n);
    y_in = v;
    for (int i = 0; i < n; i++) begin
      step();
      if (edge_pulse) begin
        pulses_seen++;
        if (first_idx < 0) first_idx = i;
      end
    end
  endtask

  task automatic clr_stats();
    pulses_seen = 0;
    first_idx   = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1; y_in = 1'b0; enable = 1'b1; clear = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_left;
    model_reset();
    #1;

    // Reset state
    do_reset();
    check_eq("reset_pulse", int'(edge_pulse), 0);
    check_eq("reset_count", int'(count), 0);
    check_eq("reset_busy", int'(busy), 0);

    // Rise latency: y high from edge 0, pulse only after edge 5
    clr_stats();
    run_level(1'b1, 12);
    check_eq("latency_idx", first_idx, SYNC_STAGES + DEBOUNCE - 1);
    check_eq("latency_pulses", pulses_seen, 1);
    check_eq("latency_count", int'(count), 1);
    check_eq("latency_ovf", int'(overflow), 0);

    // Glitch rejection: 3-cycle pulse rejected, 4-cycle pulse accepted
    do_reset();
    clr_stats();
    run_level(1'b0, 4);
    run_level(1'b1, 3);
    run_level(1'b0, 8);
    check_eq("glitch3_pulses", pulses_seen, 0);
    run_level(1'b1, 4);
    run_level(1'b0, 8);
    check_eq("glitch4_pulses", pulses_seen, 1);
    check_eq("glitch4_count", int'(count), 1);

    // Wrap: 256 clean edges
    do_reset();
    for (int e = 1; e <= 256; e++) begin
      run_level(1'b1, 6);
      run_level(1'b0, 6);
      if (e == 255) begin
        check_eq("wrap_count255", int'(count), 255);
        check_eq("wrap_ovf255", int'(overflow), 0);
      end
    end
    check_eq("wrap_count0", int'(count), 0);
    check_eq("wrap_ovf", int'(overflow), 1);
    run_level(1'b1, 6);
    run_level(1'b0, 6);
    check_eq("wrap_ovf_sticky", int'(overflow), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clear_ovf", int'(overflow), 0);

    // enable gating: 3 edges disabled, 2 enabled
    do_reset();
    clr_stats();
    enable = 1'b0;
    for (int e = 0; e < 3; e++) begin
      run_level(1'b1, 6);
      run_level(1'b0, 6);
    end
    enable = 1'b1;
    for (int e = 0; e < 2; e++) begin
      run_level(1'b1, 6);
      run_level(1'b0, 6);
    end
    check_eq("enable_pulses", pulses_seen, 5);
    check_eq("enable_count", int'(count), 2);

    // clear coincident with a qualified edge
    run_level(1'b1, 5);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clearedge_pulse", int'(edge_pulse), 1);
    check_eq("clearedge_count", int'(count), 0);
    check_eq("clearedge_ovf", int'(overflow), 0);
    run_level(1'b0, 8);

    // Reset during RISE_CHK with dcnt=2, y_in held high through release
    do_reset();
    run_level(1'b1, 4);
    check_eq("midrise_busy", int'(busy), 1);
    rst = 1'b1;
    step();
    step();
    check_eq("inreset_pulse", int'(edge_pulse), 0);
    check_eq("inreset_busy", int'(busy), 0);
    check_eq("inreset_count", int'(count), 0);
    rst = 1'b0;
    clr_stats();
    run_level(1'b1, 10);
    check_eq("postrst_idx", first_idx, SYNC_STAGES + DEBOUNCE - 1);
    check_eq("postrst_pulses", pulses_seen, 1);
    check_eq("postrst_count", int'(count), 1);

    // Randomized run against the model
    run_left = 0;
    for (int c = 0; c < 2500; c++) begin
      if (run_left == 0) begin
        y_in = ~y_in;
        run_left = $urandom_range(1, 7);
      end
      run_left--;
      enable = ($urandom_range(0, 3) != 0);
      clear  = ($urandom_range(0, 40) == 0);
      rst    = ($urandom_range(0, 300) == 0);
      step();
    end
    rst = 1'b0; clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
